automata_sequencer: RTL and testbench
=====================================

# automata_sequencer

Script-driven controller for the 8-input / 8-output control automaton (3-bit state, synchronous `rst`, step enable `en`). The sequencer holds a 16-entry script of input vectors. On command it resets the automaton and steps it once per script entry, driving its `en`/`U` and sampling its `C`/`state` after every step. It folds each `C` into an 8-bit signature, stops early on a programmable target state, and reports completion. It sits between the test/console logic and the automaton instance.

## Interface
- `DEPTH`, 16: script entries; fixed at 16, so address width is 4.
- `clk`  in  1: clock; all registers update on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `wr_en`  in  1: script write strobe. Ignored while `busy`=1.
- `wr_addr`  in  4: script write address.
- `wr_data`  in  8: `U` vector to store.
- `len`  in  5: number of steps per run, 1..16. Values 0 and >16 are illegal; `start` is ignored.
- `start`  in  1: run request, sampled only while `busy`=0.
- `abort`  in  1: terminate the current run, sampled only while `busy`=1.
- `stop_en`  in  1: enable early stop on a target state.
- `stop_state`  in  3: target automaton state.
- `auto_C`  in  8: automaton output `C`.
- `auto_state`  in  3: automaton `state`.
- `auto_rst`  out  1: to the automaton's `rst`.
- `auto_en`  out  1: to the automaton's `en`.
- `auto_U`  out  8: to the automaton's `U`.
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle end-of-run pulse.
- `hit`  out  1: the last run ended on `stop_state`.
- `steps`  out  5: steps completed in the last or current run.
- `sig`  out  8: signature of the sampled `C` values.

## Operation
- All outputs and the script memory are registered and reset to 0. The FSM resets to IDLE.
- FSM states:
  - **IDLE**: `busy`=0. `wr_en` writes `mem[wr_addr]`<=`wr_data`. A `start` with legal `len` clears `sig`, `steps`, `hit` and the pointer, sets `busy`=1 and `auto_rst`=1, and moves to INIT.
  - **INIT**: `auto_rst`<=0, `auto_en`<=1, `auto_U`<=`mem[0]`. Moves to STEP.
  - **STEP**: `auto_en`<=0 (the automaton steps on this edge). Moves to SAMPLE.
  - **SAMPLE**: on this edge:
    - `sig`<={`sig[6:0]`,`sig[7]`} ^ `auto_C`.
    - `steps`<=`steps`+1.
    - If `stop_en` and `auto_state`==`stop_state`: `hit`<=1, finish.
    - Else if `steps`+1==`len`: finish.
    - Else: pointer+1, `auto_en`<=1, `auto_U`<=`mem[pointer+1]`, move to STEP.
  - **Finish**: `done`<=1 and `busy`<=0 on the same edge; FSM returns to IDLE. `done` clears on the next edge.
- `auto_U` holds its last value when idle; it is 0 after reset.
- **Abort**: `abort`=1 in INIT, STEP or SAMPLE forces, on that edge:
  - `auto_en`<=0, `auto_rst`<=0, `done`<=1, `busy`<=0, `hit`<=0, FSM to IDLE.
  - `sig` and `steps` keep their partial values.
  - Abort has priority over the SAMPLE decisions.
- `start` while busy: ignored. `wr_en` while busy: ignored, memory unchanged.
- Asserting `rst` mid-run immediately clears everything, including the script, and drives `auto_en`=`auto_rst`=0.
- `sig`, `steps` and `hit` are held after `done` until the next accepted `start`.

## Timing
Let E0 be the edge that samples `start`.
- E0 to E1: `auto_rst`=1, so the automaton resets at E1.
- Step i: `auto_en`=1 with `auto_U`=`mem[i]` during the cycle before edge E(2i+2).
- Step i is sampled at E(2i+3).
- A full run raises `done` at E(2·len+1), high for exactly one cycle.
- An early stop after step i raises `done` at E(2i+3).
- Throughput: one automaton step per 2 cycles. A new `start` is accepted on the edge after `done` rises.

## Test plan
- **Full run.** Script [0x00,0x08], `len`=2, `stop_en`=0. Required:
  - `done` at E5, `steps`=2.
  - Sampled C = 0x83 then 0x84; `sig`=0x83, `hit`=0.
  - Final `auto_state`=2.
- **Three-step chain.** Script [0x00,0x40,0x00], `len`=3. Required:
  - C sequence 0x83, 0xF5, 0x28; `sig`=0xCD.
  - `steps`=3, `auto_state`=3, `done` at E7.
- **Early stop.** Script [0x00,0x08,0x08,0x08], `len`=4, `stop_en`=1, `stop_state`=2. Required:
  - `hit`=1, `steps`=1, `sig`=0x83, `done` at E3.
  - `auto_en` is never asserted a second time.
- **Abort.** Same script as the early-stop case, `stop_en`=0, `abort` pulsed at E4. Required:
  - `done` at E4, `busy`=0, `hit`=0, `steps`=1, `sig`=0x83.
  - `auto_en`=0 from E4.
- **Guards.** `wr_en` to addr 0 with 0xFF mid-run, then a re-run. Required: identical results to the full-run case, since the write was dropped. `start` with `len`=0: `busy` stays 0, no `done`.
- **Reset mid-run.** Assert `rst` between E2 and E3. Required:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - The script reads back as 0: a rerun with `len`=1 gives C=0x83.

Source files
------------

// File: rtl/automata_sequencer.sv
// Script-driven sequencer for the 8-in/8-out control automaton.
// Replays up to 16 stored U vectors, one step per two clocks, and signs the C outputs.
module automata_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] len,
    input  logic       start,
    input  logic       abort,
    input  logic       stop_en,
    input  logic [2:0] stop_state,
    input  logic [7:0] auto_C,
    input  logic [2:0] auto_state,
    output logic       auto_rst,
    output logic       auto_en,
    output logic [7:0] auto_U,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [4:0] steps,
    output logic [7:0] sig
);

    typedef enum logic [1:0] {IDLE, INIT, STEP, SAMPLE} state_t;

    state_t     state, state_nx;
    logic [7:0] mem [DEPTH];
    logic [3:0] ptr;
    logic [3:0] ptr_inc;
    logic [4:0] steps_inc;
    logic       len_ok;
    logic       go;
    logic       at_stop;
    logic       last;

    assign len_ok    = (len != 5'd0) && (len <= 5'(DEPTH));
    assign go        = (state == IDLE) && start && len_ok;
    assign ptr_inc   = ptr + 4'd1;
    assign steps_inc = steps + 5'd1;
    assign at_stop   = stop_en && (auto_state == stop_state);
    assign last      = (steps_inc == len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (go) state_nx = INIT;
            INIT:   state_nx = abort ? IDLE : STEP;
            STEP:   state_nx = abort ? IDLE : SAMPLE;
            SAMPLE: begin
                if (abort || at_stop || last) state_nx = IDLE;
                else                          state_nx = STEP;
            end
        endcase
    end

    // Abort wins over every per-state action; sig/steps keep partial values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr      <= '0;
            auto_rst <= 1'b0;
            auto_en  <= 1'b0;
            auto_U   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit      <= 1'b0;
            steps    <= '0;
            sig      <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                auto_en  <= 1'b0;
                auto_rst <= 1'b0;
                done     <= 1'b1;
                busy     <= 1'b0;
                hit      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (wr_en) mem[wr_addr] <= wr_data;
                        if (go) begin
                            sig      <= '0;
                            steps    <= '0;
                            hit      <= 1'b0;
                            ptr      <= '0;
                            busy     <= 1'b1;
                            auto_rst <= 1'b1;
                        end
                    end
                    INIT: begin
                        auto_rst <= 1'b0;
                        auto_en  <= 1'b1;
                        auto_U   <= mem[0];
                    end
                    STEP: auto_en <= 1'b0;
                    SAMPLE: begin
                        sig   <= {sig[6:0], sig[7]} ^ auto_C;
                        steps <= steps_inc;
                        if (at_stop) begin
                            hit  <= 1'b1;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else if (last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            ptr     <= ptr_inc;
                            auto_en <= 1'b1;
                            auto_U  <= mem[ptr_inc];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_automata_sequencer.sv
// Bench for automata_sequencer: toy automaton, directed cases, random runs.
// Expected results come from a step-list reference model of a whole run.
module tb_automata_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] len;
    logic       start;
    logic       abort;
    logic       stop_en;
    logic [2:0] stop_state;
    logic [7:0] auto_C;
    logic [2:0] auto_state;
    logic       auto_rst;
    logic       auto_en;
    logic [7:0] auto_U;
    logic       busy;
    logic       done;
    logic       hit;
    logic [4:0] steps;
    logic [7:0] sig;

    int         npass = 0;
    int         ntotal = 0;
    int         en_total = 0;
    logic [7:0] script [16];

    automata_sequencer #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .abort(abort),
        .stop_en(stop_en), .stop_state(stop_state),
        .auto_C(auto_C), .auto_state(auto_state),
        .auto_rst(auto_rst), .auto_en(auto_en), .auto_U(auto_U),
        .busy(busy), .done(done), .hit(hit),
        .steps(steps), .sig(sig)
    );

    always #5 clk = ~clk;

    // Stand-in automaton: returns {next_state, C}
    function automatic logic [10:0] auto_next(input logic [2:0] s,
                                              input logic [7:0] u);
        logic [2:0] ns;
        logic [7:0] c;
        ns = (s + u[2:0] + 3'd1) ^ {2'b00, u[7]};
        c  = {ns, 5'b10011} ^ u ^ {5'b0, s};
        return {ns, c};
    endfunction

    always @(posedge clk) begin
        if (auto_rst) begin
            auto_state <= 3'd0;
            auto_C     <= 8'd0;
        end else if (auto_en) begin
            {auto_state, auto_C} <= auto_next(auto_state, auto_U);
        end
        if (auto_en) en_total <= en_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_script();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = script[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Reference: run nmax steps of the script, stopping on a matched state
    task automatic model(input int nmax, output logic [7:0] s,
                         output int st, output bit h,
                         output logic [2:0] fs);
        logic [2:0]  a;
        logic [10:0] r;
        a  = 3'd0;
        s  = 8'd0;
        st = 0;
        h  = 1'b0;
        for (int i = 0; i < nmax; i++) begin
            r = auto_next(a, script[i]);
            a = r[10:8];
            s = {s[6:0], s[7]} ^ r[7:0];
            st++;
            if (stop_en && a == stop_state) begin
                h = 1'b1;
                break;
            end
        end
        fs = a;
    endtask

    task automatic do_run(input int ab_k, input bit guard);
        logic [7:0] es;
        logic [2:0] efs;
        int         est;
        bit         eh;
        int         nmax;
        int         edone;
        int         een;
        int         base;
        int         k;
        if (ab_k > 0) nmax = (ab_k < 2) ? 0 : (ab_k - 2) / 2;
        else          nmax = int'(len);
        model(nmax, es, est, eh, efs);
        edone = (ab_k > 0) ? ab_k : 2 * est + 1;
        een   = (ab_k > 0) ? ab_k / 2 : est;
        base  = en_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 100 && !done) begin
            k++;
            abort = (k == ab_k);
            if (guard && k == 2) begin
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = ~script[0];
                start   = 1'b1;
            end
            tick();
            abort = 1'b0;
            wr_en = 1'b0;
            start = 1'b0;
        end
        check("done_edge", k, edone);
        check("steps", steps, est);
        check("sig", sig, es);
        check("hit", hit, eh);
        check("busy_end", busy, 0);
        check("auto_en_end", auto_en, 0);
        check("en_count", en_total - base, een);
        if (ab_k == 0) check("auto_state", auto_state, efs);
        tick();
        check("done_pulse", done, 0);
    endtask

    task automatic bad_len(input logic [4:0] l);
        bit seen;
        seen  = 1'b0;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy || done) seen = 1'b1;
            tick();
        end
        check("bad_len_ignored", seen, 0);
    endtask

    initial begin
        logic [10:0] r;
        int          ab;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        len        = 5'd1;
        start      = 1'b0;
        abort      = 1'b0;
        stop_en    = 1'b0;
        stop_state = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_steps", steps, 0);
        check("rst_sig", sig, 0);
        check("rst_auto_en", auto_en, 0);
        check("rst_auto_rst", auto_rst, 0);
        check("rst_auto_U", auto_U, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) script[i] = 8'($urandom);
        load_script();

        len = 5'd2;
        do_run(0, 1'b0);

        len = 5'd16;
        do_run(0, 1'b0);

        r          = auto_next(3'd0, script[0]);
        stop_en    = 1'b1;
        stop_state = r[10:8];
        len        = 5'd4;
        do_run(0, 1'b0);
        stop_en = 1'b0;

        len = 5'd4;
        do_run(4, 1'b0);

        len = 5'd3;
        do_run(0, 1'b1);
        do_run(0, 1'b0);

        bad_len(5'd0);
        bad_len(5'd17);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 16; i++) script[i] = 8'($urandom);
            load_script();
            len        = 5'($urandom_range(1, 16));
            stop_en    = 1'($urandom);
            stop_state = 3'($urandom);
            ab = 0;
            if ($urandom_range(0, 3) == 0) begin
                stop_en = 1'b0;
                ab      = $urandom_range(1, 2 * int'(len));
            end
            do_run(ab, 1'($urandom));
        end

        stop_en = 1'b0;
        len     = 5'd8;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_auto_en", auto_en, 0);
        check("mid_rst_auto_rst", auto_rst, 0);
        check("mid_rst_auto_U", auto_U, 0);
        check("mid_rst_sig", sig, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) script[i] = 8'd0;
        len = 5'd16;
        do_run(0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
